// File: rtl/nios2_mul_sequencer.sv
// -----------------------------------------------------------------------------
// nios2_mul_sequencer
//
// Multi-cycle 32x32 multiply controller for the Nios II execute stage. One
// registered 16x16 unsigned multiplier cell is time-shared across the four
// partial products of a 32x32 multiply. The partial products are summed into
// a 64-bit accumulator, and a final correction step turns the unsigned high
// word into the signed/unsigned variants.
//
// Ports
//   clk      in   1  system clock, all state changes on the rising edge
//   reset_n  in   1  synchronous active-low reset
//   start    in   1  operation request, only looked at while busy=0
//   op       in   2  00 MUL (low word), 01 MULXUU, 10 MULXSU, 11 MULXSS
//   src1     in  32  operand A, captured when start is accepted
//   src2     in  32  operand B, captured when start is accepted
//   busy     out  1  high from the cycle after accept through the done cycle
//   done     out  1  one-cycle pulse, result valid in the same cycle
//   result   out 32  product word, held until the next done
//
// Timing: accept at edge E0, ISSUE k=0..3 during the four following cycles,
// one DRAIN cycle, one CORR cycle, then the DONE cycle with done=1. The
// latency is fixed at 7 cycles and the next request can be accepted in the
// IDLE cycle right after DONE (8-cycle throughput).
// -----------------------------------------------------------------------------
module nios2_mul_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_CORR  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXUU = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic [31:0] a_q,        a_d;          // latched operand A
    logic [31:0] b_q,        b_d;          // latched operand B
    logic [1:0]  op_q,       op_d;         // latched opcode
    logic [1:0]  k_q,        k_d;          // partial-product issue index
    logic [63:0] acc_q,      acc_d;        // 64-bit product accumulator
    logic [31:0] pp_q,       pp_d;         // multiplier cell output register
    logic [5:0]  pp_shift_q, pp_shift_d;   // shift tag travelling with pp_q
    logic        pp_vld_q,   pp_vld_d;     // pp_q holds a fresh product
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [31:0] result_q,   result_d;

    // Combinational helpers
    logic [15:0] cell_a;
    logic [15:0] cell_b;
    logic [31:0] cell_p;
    logic [5:0]  cell_shift;
    logic [63:0] pp_aligned;
    logic [31:0] hi_word;
    logic [31:0] corr_a;                   // B when A is negative
    logic [31:0] corr_b;                   // A when B is negative
    logic [31:0] corrected;

    // -------------------------------------------------------------------------
    // Multiplier cell operand selection and correction terms
    // -------------------------------------------------------------------------
    always_comb begin
        // k[1] picks the half of A, k[0] the half of B:
        // k=0 lo*lo, k=1 lo*hi, k=2 hi*lo, k=3 hi*hi.
        cell_a = k_q[1] ? a_q[31:16] : a_q[15:0];
        cell_b = k_q[0] ? b_q[31:16] : b_q[15:0];
        cell_p = {16'd0, cell_a} * {16'd0, cell_b};

        // Weight of each partial product: the two cross terms share 16.
        case (k_q)
            2'd0:    cell_shift = 6'd0;
            2'd3:    cell_shift = 6'd32;
            default: cell_shift = 6'd16;
        endcase

        pp_aligned = {32'd0, pp_q} << pp_shift_q;

        // The accumulator holds the unsigned product. A two's-complement
        // operand with its sign bit set is worth 2^32 less than its unsigned
        // reading, so the signed high word is the unsigned one minus the
        // other operand for every negative operand (modulo 2^32).
        hi_word = acc_q[63:32];
        corr_a  = a_q[31] ? b_q : 32'd0;
        corr_b  = b_q[31] ? a_q : 32'd0;

        case (op_q)
            OP_MUL:    corrected = acc_q[31:0];
            OP_MULXUU: corrected = hi_word;
            OP_MULXSU: corrected = hi_word - corr_a;
            OP_MULXSS: corrected = hi_word - corr_a - corr_b;
            default:   corrected = hi_word;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        k_d        = k_q;
        acc_d      = acc_q;
        pp_d       = pp_q;
        pp_shift_d = pp_shift_q;
        pp_vld_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;

        // The cell registers one product per ISSUE cycle; its shift tag is
        // registered alongside so the accumulate a cycle later uses the
        // matching weight.
        if (state_q == S_ISSUE) begin
            pp_d       = cell_p;
            pp_shift_d = cell_shift;
            pp_vld_d   = 1'b1;
        end

        // Accumulate in the cycle after each issue (ISSUE k=1..3 and DRAIN).
        if (pp_vld_q) begin
            acc_d = acc_q + pp_aligned;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = op;
                    k_d     = 2'd0;
                    acc_d   = 64'd0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_CORR;
            end
            S_CORR: begin
                // acc_q is complete here: the last accumulate ran in DRAIN.
                result_d = corrected;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                // start is ignored here; the next accept is in IDLE.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= OP_MUL;
            k_q        <= 2'd0;
            acc_q      <= 64'd0;
            pp_q       <= 32'd0;
            pp_shift_q <= 6'd0;
            pp_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            pp_q       <= pp_d;
            pp_shift_q <= pp_shift_d;
            pp_vld_q   <= pp_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for nios2_mul_sequencer. Directed scenarios with constant expected
// values plus randomized operations checked against a reference model that
// computes the product with 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_nios2_mul_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam int LAT = 7;

    nios2_mul_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src1    (src1),
        .src2    (src2),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the mathematical product, then word selection.
    function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint p;
        case (o)
            2'b00: p = longint'({32'd0, a}) * longint'({32'd0, b});
            2'b01: p = longint'({32'd0, a}) * longint'({32'd0, b});
            2'b10: p = longint'($signed(a)) * longint'({32'd0, b});
            default: p = longint'($signed(a)) * longint'($signed(b));
        endcase
        if (o == 2'b00) return p[31:0];
        return p[63:32];
    endfunction

    // Drive one operation as soon as the block is idle; report the result,
    // the number of cycles from accept to done, and cycles with busy low.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int busy_bad);
        int guard;
        res = 'x;
        lat = -1;
        busy_bad = 0;
        @(negedge clk);
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        // Scramble inputs: latched operands must not follow them.
        start = 1'b0;
        op    = 2'($urandom);
        src1  = $urandom;
        src2  = $urandom;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!busy) busy_bad++;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        reset_n = 1'b0;
        start   = 1'b1;
        op      = 2'b00;
        src1    = 32'h0000_0003;
        src2    = 32'h0000_0003;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        // Release reset with start still high: accepted in the first cycle.
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src1  = 32'hDEAD_BEEF;
        src2  = 32'h1234_5678;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
        $display("reset_release op=0 a=00000003 b=00000003 result=%h lat=%0d", result, lat);
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL reset_first_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if (result !== 32'h0000_0009) begin errors++; $display("FAIL reset_first_result: got %h want 00000009", result); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [4];
        logic [31:0] r;
        int lat, bb;
        exp_r[0] = 32'h0000_0001;
        exp_r[1] = 32'hFFFF_FFFE;
        exp_r[2] = 32'hFFFF_FFFF;
        exp_r[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bb);
            $display("all_ones op=%0d result=%h exp=%h lat=%0d", i, r, exp_r[i], lat);
            checks++;
            if (r !== exp_r[i]) begin errors++; $display("FAIL all_ones_op%0d: got %h want %h", i, r, exp_r[i]); end
            checks++;
            if (lat != LAT || bb != 0) begin errors++; $display("FAIL all_ones_timing_op%0d: lat %0d busy_low %0d want %0d/0", i, lat, bb, LAT); end
        end
        // done must drop after one cycle and busy with it.
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_single_cycle: done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_cross_and_signed();
        logic [1:0]  t_op  [5];
        logic [31:0] t_a   [5];
        logic [31:0] t_b   [5];
        logic [31:0] t_exp [5];
        logic [31:0] r;
        int lat, bb;
        t_op[0] = 2'b00; t_a[0] = 32'h0001_0000; t_b[0] = 32'h0001_0000; t_exp[0] = 32'h0000_0000;
        t_op[1] = 2'b01; t_a[1] = 32'h0001_0000; t_b[1] = 32'h0001_0000; t_exp[1] = 32'h0000_0001;
        t_op[2] = 2'b01; t_a[2] = 32'h0000_FFFF; t_b[2] = 32'hFFFF_0001; t_exp[2] = 32'h0000_FFFE;
        t_op[3] = 2'b11; t_a[3] = 32'h8000_0000; t_b[3] = 32'h0000_0002; t_exp[3] = 32'hFFFF_FFFF;
        t_op[4] = 2'b10; t_a[4] = 32'h8000_0000; t_b[4] = 32'h0000_0002; t_exp[4] = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], r, lat, bb);
            $display("directed op=%0d a=%h b=%h result=%h exp=%h lat=%0d", t_op[i], t_a[i], t_b[i], r, t_exp[i], lat);
            checks++;
            if (r !== t_exp[i] || lat != LAT) begin
                errors++;
                $display("FAIL directed_%0d: got %h lat %0d want %h lat %0d", i, r, lat, t_exp[i], LAT);
            end
        end
        run_op(2'b01, 32'h8000_0000, 32'h0000_0002, r, lat, bb);
        $display("directed op=1 a=80000000 b=00000002 result=%h exp=00000001 lat=%0d", r, lat);
        checks++;
        if (r !== 32'h0000_0001) begin errors++; $display("FAIL signed_mixed_uu: got %h want 00000001", r); end
    endtask

    task automatic test_busy_reject();
        int ndone, lat;
        logic [31:0] r1;
        r1 = 'x;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; src1 = 32'd5; src2 = 32'd7;
        @(posedge clk);
        #1;
        // Keep requesting with other operands through the DONE cycle.
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            start = 1'b1;
            op    = 2'b01;
            src1  = $urandom;
            src2  = $urandom;
            if (done) begin ndone++; r1 = result; end
        end
        // First IDLE cycle: a new request is accepted.
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reject_idle: busy=%b done=%b want 0/0", busy, done); end
        start = 1'b1; op = 2'b00; src1 = 32'd11; src2 = 32'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
        $display("busy_reject first=%h dones=%0d second=%h lat=%0d", r1, ndone, result, lat);
        checks++;
        if (ndone != 1 || r1 !== 32'd35) begin errors++; $display("FAIL reject_first: dones %0d result %h want 1 and 00000023", ndone, r1); end
        checks++;
        if (lat != LAT || result !== 32'd143) begin errors++; $display("FAIL reject_next_accept: lat %0d result %h want %0d and 0000008f", lat, result, LAT); end
    endtask

    task automatic test_midop_reset();
        int ndone, lat, bb;
        logic [31:0] r;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b11; src1 = 32'h1357_9BDF; src2 = 32'h0246_8ACE;
        @(posedge clk);            // E0
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);            // E3 with reset asserted
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL midop_reset_state: busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0 || result !== 32'd0) begin errors++; $display("FAIL midop_no_done: dones %0d result %h want 0/0", ndone, result); end
        run_op(2'b00, 32'h0000_1000, 32'h0000_0010, r, lat, bb);
        $display("midop_reset recovery result=%h lat=%0d dones_after_reset=%0d", r, lat, ndone);
        checks++;
        if (r !== 32'h0001_0000 || lat != LAT) begin errors++; $display("FAIL midop_recovery: got %h lat %0d want 00010000 lat %0d", r, lat, LAT); end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, r, e;
        int lat, bb;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = {1'b1, 31'($urandom)};
                1: b = {1'b1, 31'($urandom)};
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            e = ref_mul(o, a, b);
            run_op(o, a, b, r, lat, bb);
            $display("random %0d op=%0d a=%h b=%h result=%h exp=%h lat=%0d", i, o, a, b, r, e, lat);
            checks++;
            if (r !== e) begin errors++; $display("FAIL random_%0d_result: got %h want %h", i, r, e); end
            checks++;
            if (lat != LAT || bb != 0) begin errors++; $display("FAIL random_%0d_timing: lat %0d busy_low %0d want %0d/0", i, lat, bb, LAT); end
        end
    endtask

    initial begin
        start = 1'b0;
        op    = 2'b00;
        src1  = 32'd0;
        src2  = 32'd0;
        reset_n = 1'b0;
        test_reset();
        test_back_to_back();
        test_cross_and_signed();
        test_busy_reject();
        test_midop_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
